mul_csa_seq: RTL

// - Iterative radix-4 carry-save multiplier controller for the FPU significand path.
// - Each cycle it retires two multiplier bits: it folds two shifted partial products into a

---
 rtl/mul_csa_seq_if.sv | 25 ++
 rtl/mul_csa_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mul_csa_seq_if.sv
// mul_csa_seq_if: operand/product handshake bundle for the iterative
// carry-save multiplier. The master side offers operands and consumes the
// product; the slave side is the multiplier.
interface mul_csa_seq_if #(
    parameter int N = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_p;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy
    );
endinterface

// File: rtl/mul_csa_seq.sv
// mul_csa_seq: iterative radix-4 carry-save multiplier for the FPU
// significand path. Two multiplier bits retire per ITER cycle through a 4:2
// compressor into a redundant sum/carry pair; one carry-propagate add in
// RESOLVE produces the 2N-bit product. One multiplication in flight.
// Optional feature macro: EARLY_TERM_EN -- leave ITER as soon as no
// multiplier bits remain above the pair being consumed.
module mul_csa_seq #(
    parameter  int N  = 24,
    localparam int CW = $clog2(N/2)
) (
    input  logic            clk,
    input  logic            rst,
    mul_csa_seq_if.slave    bus
);
    localparam int          W        = 2 * N;
    localparam logic [CW-1:0] LAST_CNT = CW'(N/2 - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITER    = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // 4:2 compressor built from two carry-save layers; returns {carry, sum}
    // truncated to W bits (exact because the product never reaches 2^W).
    function automatic logic [2*W-1:0] ftadd(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic [W-1:0] z,
        input logic [W-1:0] w
    );
        logic [W-1:0] s1;
        logic [W-1:0] c1;
        logic [W-1:0] s2;
        logic [W-1:0] c2;
        s1 = x ^ y ^ z;
        c1 = ((x & y) | (x & z) | (y & z)) << 1;
        s2 = s1 ^ w ^ c1;
        c2 = ((s1 & w) | (s1 & c1) | (w & c1)) << 1;
        return {c2, s2};
    endfunction

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [W-1:0]     car_q, car_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     out_p_q, out_p_d;
    logic             out_valid_q, out_valid_d;

    logic [W-1:0]     pp0;
    logic [W-1:0]     pp1;
    logic [2*W-1:0]   csa;
    logic             iter_last;

`ifdef EARLY_TERM_EN
    // Stop once the pair being consumed now is the last non-zero one.
    assign iter_last = (cnt_q == LAST_CNT) || (b_q[N-1:2] == '0);
`else
    assign iter_last = (cnt_q == LAST_CNT);
`endif

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.busy      = (state_q == ITER) || (state_q == RESOLVE);

    // Next-state and datapath update for the accept/iterate/resolve/hold sequence.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        car_d       = car_q;
        cnt_d       = cnt_q;
        out_p_d     = out_p_q;
        out_valid_d = out_valid_q;
        pp0         = b_q[0] ? a_q : '0;
        pp1         = b_q[1] ? (a_q << 1) : '0;
        csa         = ftadd(sum_q, car_q, pp0, pp1);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = {{N{1'b0}}, bus.in_a};
                    b_d     = bus.in_b;
                    sum_d   = '0;
                    car_d   = '0;
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                sum_d = csa[W-1:0];
                car_d = csa[2*W-1:W];
                a_d   = a_q << 2;
                b_d   = b_q >> 2;
                cnt_d = cnt_q + 1'b1;
                if (iter_last) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                out_p_d     = sum_q + car_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            car_q       <= '0;
            cnt_q       <= '0;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            car_q       <= car_d;
            cnt_q       <= cnt_d;
            out_p_q     <= out_p_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
